// File: rtl/beehive_udp_msg.sv
// UDP message descriptor shared by the response path of the UDP engine.
package beehive_udp_msg;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info;

  localparam int UDP_INFO_W = $bits(udp_info);

endpackage

// File: rtl/bsg_mux.sv
// Generic N-way one-hot-free mux selected by a binary index.
module bsg_mux #(
  parameter  int width_p   = 1,
  parameter  int els_p     = 2,
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic [els_p-1:0][width_p-1:0] data_i,
  input  logic [lg_els_lp-1:0]          sel_i,
  output logic [width_p-1:0]            data_o
);

  assign data_o = data_i[sel_i];

endmodule

// File: rtl/vr_resp_arbiter.sv
// Round-robin merge of the setup and manage response streams into one
// meta+data stream, one whole message per grant.
module vr_resp_arbiter
  import beehive_udp_msg::*;
#(
  parameter int NOC_DATA_W     = -1,
  parameter int NOC_PADBYTES_W = $clog2(NOC_DATA_W/8)
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      setup_arb_meta_val,
  input  udp_info                   setup_arb_meta_info,
  output logic                      arb_setup_meta_rdy,
  input  logic                      setup_arb_data_val,
  input  logic [NOC_DATA_W-1:0]     setup_arb_data,
  input  logic                      setup_arb_data_last,
  input  logic [NOC_PADBYTES_W-1:0] setup_arb_data_padbytes,
  output logic                      arb_setup_data_rdy,

  input  logic                      manage_arb_meta_val,
  input  udp_info                   manage_arb_meta_info,
  output logic                      arb_manage_meta_rdy,
  input  logic                      manage_arb_data_val,
  input  logic [NOC_DATA_W-1:0]     manage_arb_data,
  input  logic                      manage_arb_data_last,
  input  logic [NOC_PADBYTES_W-1:0] manage_arb_data_padbytes,
  output logic                      arb_manage_data_rdy,

  output logic                      arb_to_udp_meta_val,
  output udp_info                   arb_to_udp_meta_info,
  input  logic                      to_udp_arb_meta_rdy,

  output logic                      arb_to_udp_data_val,
  output logic [NOC_DATA_W-1:0]     arb_to_udp_data,
  output logic                      arb_to_udp_data_last,
  output logic [NOC_PADBYTES_W-1:0] arb_to_udp_data_padbytes,
  input  logic                      to_udp_arb_data_rdy
);

  // Handshake: a beat transfers on a rising clk edge where val and rdy are
  // both high; a source holds val and payload stable until that edge.

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    META_OUT  = 2'd1,
    DATA_PASS = 2'd2
  } state_e;

  state_e state_r, state_next;
  logic   grant_r, grant_next;
  logic   prio_r, prio_next;
  logic   meta_phase, data_phase;

  logic   sel_meta_val, sel_data_val, sel_data_last;

  // Payload buses follow the grant at all times; val gates their meaning.
  assign sel_meta_val             = grant_r ? manage_arb_meta_val      : setup_arb_meta_val;
  assign sel_data_val             = grant_r ? manage_arb_data_val      : setup_arb_data_val;
  assign sel_data_last            = grant_r ? manage_arb_data_last     : setup_arb_data_last;
  assign arb_to_udp_meta_info     = grant_r ? manage_arb_meta_info     : setup_arb_meta_info;
  assign arb_to_udp_data          = grant_r ? manage_arb_data          : setup_arb_data;
  assign arb_to_udp_data_last     = sel_data_last;
  assign arb_to_udp_data_padbytes = grant_r ? manage_arb_data_padbytes : setup_arb_data_padbytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB;
      grant_r <= 1'b0;
      prio_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      grant_r <= grant_next;
      prio_r  <= prio_next;
    end
  end

  always_comb begin
    state_next          = state_r;
    grant_next          = grant_r;
    prio_next           = prio_r;
    meta_phase          = 1'b0;
    data_phase          = 1'b0;
    arb_to_udp_meta_val = 1'b0;
    arb_to_udp_data_val = 1'b0;
    case (state_r)
      ARB: begin
        if (setup_arb_meta_val || manage_arb_meta_val) begin
          // Priority holder wins a tie; a lone requester always wins.
          grant_next = (setup_arb_meta_val && manage_arb_meta_val) ? prio_r
                                                                   : manage_arb_meta_val;
          state_next = META_OUT;
        end
      end
      META_OUT: begin
        meta_phase          = 1'b1;
        arb_to_udp_meta_val = sel_meta_val;
        if (sel_meta_val && to_udp_arb_meta_rdy) begin
          state_next = DATA_PASS;
        end
      end
      DATA_PASS: begin
        data_phase          = 1'b1;
        arb_to_udp_data_val = sel_data_val;
        if (sel_data_val && to_udp_arb_data_rdy && sel_data_last) begin
          state_next = ARB;
          prio_next  = ~grant_r;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Each source rdy is the downstream rdy when that source owns the current
  // phase, otherwise held low.
  bsg_mux #(.width_p(1), .els_p(2)) u_setup_meta_rdy (
    .data_i ({to_udp_arb_meta_rdy, 1'b0}),
    .sel_i  (meta_phase & ~grant_r),
    .data_o (arb_setup_meta_rdy)
  );

  bsg_mux #(.width_p(1), .els_p(2)) u_manage_meta_rdy (
    .data_i ({to_udp_arb_meta_rdy, 1'b0}),
    .sel_i  (meta_phase & grant_r),
    .data_o (arb_manage_meta_rdy)
  );

  bsg_mux #(.width_p(1), .els_p(2)) u_setup_data_rdy (
    .data_i ({to_udp_arb_data_rdy, 1'b0}),
    .sel_i  (data_phase & ~grant_r),
    .data_o (arb_setup_data_rdy)
  );

  bsg_mux #(.width_p(1), .els_p(2)) u_manage_data_rdy (
    .data_i ({to_udp_arb_data_rdy, 1'b0}),
    .sel_i  (data_phase & grant_r),
    .data_o (arb_manage_data_rdy)
  );

endmodule

// File: tb/tb_vr_resp_arbiter.sv
// Directed and randomised checks of the setup/manage response arbiter.
module tb_vr_resp_arbiter;
  import beehive_udp_msg::*;

  localparam int DW     = 64;
  localparam int PW     = 3;
  localparam int INFO_W = $bits(udp_info);
  localparam int DE_W   = DW + PW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          setup_arb_meta_val, arb_setup_meta_rdy;
  udp_info       setup_arb_meta_info;
  logic          setup_arb_data_val, setup_arb_data_last, arb_setup_data_rdy;
  logic [DW-1:0] setup_arb_data;
  logic [PW-1:0] setup_arb_data_padbytes;
  logic          manage_arb_meta_val, arb_manage_meta_rdy;
  udp_info       manage_arb_meta_info;
  logic          manage_arb_data_val, manage_arb_data_last, arb_manage_data_rdy;
  logic [DW-1:0] manage_arb_data;
  logic [PW-1:0] manage_arb_data_padbytes;
  logic          arb_to_udp_meta_val, to_udp_arb_meta_rdy;
  udp_info       arb_to_udp_meta_info;
  logic          arb_to_udp_data_val, arb_to_udp_data_last, to_udp_arb_data_rdy;
  logic [DW-1:0] arb_to_udp_data;
  logic [PW-1:0] arb_to_udp_data_padbytes;

  vr_resp_arbiter #(.NOC_DATA_W(DW), .NOC_PADBYTES_W(PW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .setup_arb_meta_val       (setup_arb_meta_val),
    .setup_arb_meta_info      (setup_arb_meta_info),
    .arb_setup_meta_rdy       (arb_setup_meta_rdy),
    .setup_arb_data_val       (setup_arb_data_val),
    .setup_arb_data           (setup_arb_data),
    .setup_arb_data_last      (setup_arb_data_last),
    .setup_arb_data_padbytes  (setup_arb_data_padbytes),
    .arb_setup_data_rdy       (arb_setup_data_rdy),
    .manage_arb_meta_val      (manage_arb_meta_val),
    .manage_arb_meta_info     (manage_arb_meta_info),
    .arb_manage_meta_rdy      (arb_manage_meta_rdy),
    .manage_arb_data_val      (manage_arb_data_val),
    .manage_arb_data          (manage_arb_data),
    .manage_arb_data_last     (manage_arb_data_last),
    .manage_arb_data_padbytes (manage_arb_data_padbytes),
    .arb_manage_data_rdy      (arb_manage_data_rdy),
    .arb_to_udp_meta_val      (arb_to_udp_meta_val),
    .arb_to_udp_meta_info     (arb_to_udp_meta_info),
    .to_udp_arb_meta_rdy      (to_udp_arb_meta_rdy),
    .arb_to_udp_data_val      (arb_to_udp_data_val),
    .arb_to_udp_data          (arb_to_udp_data),
    .arb_to_udp_data_last     (arb_to_udp_data_last),
    .arb_to_udp_data_padbytes (arb_to_udp_data_padbytes),
    .to_udp_arb_data_rdy      (to_udp_arb_data_rdy)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [INFO_W-1:0] exp_meta_q0[$], exp_meta_q1[$];
  logic [DE_W-1:0]   exp_q0[$], exp_q1[$];
  int   meta_cyc_q[$];
  int   beat_cyc_q[$];
  logic order_q[$];
  int   n_meta[2]  = '{0, 0};
  int   next_id[2] = '{0, 0};
  int   req_cyc[2] = '{0, 0};
  logic in_msg     = 1'b0;
  logic cur_src    = 1'b0;
  logic abort      = 1'b0;
  logic stop_rdy   = 1'b0;
  logic [1:0] done = 2'b11;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic udp_info make_info(input logic src, input int id, input int nbeats);
    udp_info i;
    i.src_ip      = 32'hC0A8_0000 + 32'(id);
    i.dst_ip      = 32'h0A00_0000 + 32'(id * 3);
    i.src_port    = {15'h0, src};
    i.dst_port    = 16'(id);
    i.data_length = 16'(nbeats * 8);
    return i;
  endfunction

  function automatic logic [DW-1:0] beat_word(input logic src, input int id, input int idx);
    logic [23:0] id24;
    logic [31:0] idx32;
    id24  = 24'(id);
    idx32 = 32'(idx);
    return {src, 7'h0, id24, idx32};
  endfunction

  function automatic logic meta_rdy(input logic src);
    return src ? arb_manage_meta_rdy : arb_setup_meta_rdy;
  endfunction

  function automatic logic data_rdy(input logic src);
    return src ? arb_manage_data_rdy : arb_setup_data_rdy;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_meta(input logic src, input logic val, input udp_info info);
    if (src) begin
      manage_arb_meta_val = val; manage_arb_meta_info = info;
    end else begin
      setup_arb_meta_val = val; setup_arb_meta_info = info;
    end
  endtask

  task automatic set_data(input logic src, input logic val, input logic [DW-1:0] d,
                          input logic last, input logic [PW-1:0] pad);
    if (src) begin
      manage_arb_data_val = val; manage_arb_data = d;
      manage_arb_data_last = last; manage_arb_data_padbytes = pad;
    end else begin
      setup_arb_data_val = val; setup_arb_data = d;
      setup_arb_data_last = last; setup_arb_data_padbytes = pad;
    end
  endtask

  task automatic idle_gap(input int gap_pct);
    while (gap_pct > 0 && !abort && $urandom_range(0, 99) < gap_pct) begin
      @(posedge clk); #1;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_msg(input logic src, input int nbeats, input int gap_pct);
    int            id;
    udp_info       info;
    logic          hs;
    logic          last;
    logic [PW-1:0] pad;
    logic [DW-1:0] d;
    id = next_id[src];
    next_id[src]++;
    info = make_info(src, id, nbeats);
    if (src) exp_meta_q1.push_back(info); else exp_meta_q0.push_back(info);
    for (int b = 0; b < nbeats; b++) begin
      last = (b == nbeats - 1);
      pad  = last ? PW'(id) : '0;
      if (src) exp_q1.push_back({last, pad, beat_word(src, id, b)});
      else     exp_q0.push_back({last, pad, beat_word(src, id, b)});
    end
    idle_gap(gap_pct);
    set_meta(src, 1'b1, info);
    req_cyc[src] = cyc;
    hs = 1'b0;
    while (!hs && !abort) begin
      @(negedge clk); hs = meta_rdy(src);
      @(posedge clk); #1;
    end
    set_meta(src, 1'b0, info);
    for (int b = 0; b < nbeats && !abort; b++) begin
      last = (b == nbeats - 1);
      pad  = last ? PW'(id) : '0;
      d    = beat_word(src, id, b);
      idle_gap(gap_pct);
      set_data(src, 1'b1, d, last, pad);
      hs = 1'b0;
      while (!hs && !abort) begin
        @(negedge clk); hs = data_rdy(src);
        @(posedge clk); #1;
      end
      set_data(src, 1'b0, d, last, pad);
    end
  endtask

  task automatic run_src(input logic src, input int n, input int fixed_beats, input int gap_pct);
    for (int i = 0; i < n && !abort; i++)
      send_msg(src, (fixed_beats > 0) ? fixed_beats : int'($urandom_range(1, 4)), gap_pct);
    done[src] = 1'b1;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int t;
    t = 0;
    while (done != 2'b11 && t < limit) begin
      @(posedge clk); t++;
    end
    check({tag, "_timeout"}, done, 2'b11);
    if (done != 2'b11) begin
      abort = 1'b1;
      repeat (20) @(posedge clk);
    end
  endtask

  task automatic clear_logs();
    exp_meta_q0.delete(); exp_meta_q1.delete();
    exp_q0.delete(); exp_q1.delete();
    meta_cyc_q.delete(); beat_cyc_q.delete(); order_q.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    abort = 1'b0;
    set_meta(1'b0, 1'b0, '0); set_meta(1'b1, 1'b0, '0);
    set_data(1'b0, 1'b0, '0, 1'b0, '0); set_data(1'b1, 1'b0, '0, 1'b0, '0);
    to_udp_arb_meta_rdy = 1'b1;
    to_udp_arb_data_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  // ---------------- output monitor / scoreboard ----------------
  task automatic monitor_step();
    logic            src;
    logic [DE_W-1:0] got_d;
    check("vals_exclusive", arb_to_udp_meta_val & arb_to_udp_data_val, 1'b0);
    if (rst) begin
      in_msg = 1'b0;
      return;
    end
    if (arb_to_udp_meta_val && to_udp_arb_meta_rdy) begin
      src = arb_to_udp_meta_info.src_port[0];
      check("meta_inside_msg", in_msg, 1'b0);
      check("meta_rdy_owner", {arb_setup_meta_rdy, arb_manage_meta_rdy}, src ? 2'b01 : 2'b10);
      if ((src ? exp_meta_q1.size() : exp_meta_q0.size()) == 0)
        check("meta_unexpected", arb_to_udp_meta_info, '0);
      else
        check("meta_info", arb_to_udp_meta_info,
              src ? exp_meta_q1.pop_front() : exp_meta_q0.pop_front());
      in_msg  = 1'b1;
      cur_src = src;
      order_q.push_back(src);
      meta_cyc_q.push_back(cyc);
      n_meta[src]++;
    end
    if (arb_to_udp_data_val && to_udp_arb_data_rdy) begin
      src   = arb_to_udp_data[DW-1];
      got_d = {arb_to_udp_data_last, arb_to_udp_data_padbytes, arb_to_udp_data};
      check("beat_outside_msg", in_msg, 1'b1);
      check("beat_interleave", src, cur_src);
      check("data_rdy_owner", {arb_setup_data_rdy, arb_manage_data_rdy}, src ? 2'b01 : 2'b10);
      if ((src ? exp_q1.size() : exp_q0.size()) == 0)
        check("beat_unexpected", got_d, '0);
      else
        check("beat_payload", got_d, src ? exp_q1.pop_front() : exp_q0.pop_front());
      beat_cyc_q.push_back(cyc);
      if (arb_to_udp_data_last) in_msg = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   id_m, id_s, base0, base1;
    logic found;

    rst = 1'b1;
    set_meta(1'b0, 1'b1, '0); set_meta(1'b1, 1'b1, '0);
    set_data(1'b0, 1'b1, '0, 1'b1, '0); set_data(1'b1, 1'b1, '0, 1'b1, '0);
    to_udp_arb_meta_rdy = 1'b1;
    to_udp_arb_data_rdy = 1'b1;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset with every source requesting: all vals and rdys low.
    @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {arb_to_udp_meta_val, arb_to_udp_data_val, arb_setup_meta_rdy,
                          arb_setup_data_rdy, arb_manage_meta_rdy, arb_manage_data_rdy}, 6'b0);
    reset_dut();
    @(negedge clk);
    check("idle_outputs", {arb_to_udp_meta_val, arb_to_udp_data_val, arb_setup_meta_rdy,
                           arb_setup_data_rdy, arb_manage_meta_rdy, arb_manage_data_rdy}, 6'b0);

    // Setup-only 3-beat message with downstream always ready.
    @(posedge clk); #1;
    done = 2'b10;
    fork run_src(1'b0, 1, 3, 0); join_none
    @(negedge clk);
    while (cyc < req_cyc[0] + 5) @(negedge clk);
    check("single_back_in_arb", {arb_to_udp_meta_val, arb_to_udp_data_val,
                                 arb_setup_meta_rdy, arb_setup_data_rdy}, 4'b0);
    wait_done(100, "single");
    check("single_meta_cnt", meta_cyc_q.size(), 1);
    check("single_beat_cnt", beat_cyc_q.size(), 3);
    if (meta_cyc_q.size() == 1 && beat_cyc_q.size() == 3) begin
      check("single_meta_lat", meta_cyc_q[0] - req_cyc[0], 1);
      for (int i = 0; i < 3; i++)
        check("single_beat_lat", beat_cyc_q[i] - req_cyc[0], 2 + i);
    end

    // Simultaneous requests: setup first after reset, then alternate.
    reset_dut();
    done = 2'b00;
    fork
      run_src(1'b0, 2, 2, 0);
      run_src(1'b1, 2, 2, 0);
    join_none
    wait_done(200, "rr");
    check("rr_order_len", order_q.size(), 4);
    if (order_q.size() == 4)
      check("rr_order", {order_q[0], order_q[1], order_q[2], order_q[3]}, 4'b0101);

    // Back-to-back single-beat setup messages: 3 cycles each.
    reset_dut();
    done = 2'b10;
    fork run_src(1'b0, 4, 1, 0); join_none
    wait_done(200, "b2b");
    check("b2b_cnt", meta_cyc_q.size(), 4);
    if (meta_cyc_q.size() == 4) begin
      check("b2b_order", {order_q[0], order_q[1], order_q[2], order_q[3]}, 4'b0000);
      for (int i = 0; i < 3; i++)
        check("b2b_spacing", meta_cyc_q[i + 1] - meta_cyc_q[i], 3);
    end

    // Manage 4-beat message stalled 5 cycles on beat 2, setup waiting.
    reset_dut();
    id_m = next_id[1];
    done = 2'b00;
    fork
      run_src(1'b1, 1, 4, 0);
      begin
        @(posedge clk); #1;
        run_src(1'b0, 1, 1, 0);
      end
    join_none
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (arb_to_udp_data_val && arb_to_udp_data == beat_word(1'b1, id_m, 0)) found = 1'b1;
    end
    check("bp_beat1_seen", found, 1'b1);
    @(posedge clk); #1;
    to_udp_arb_data_rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_val", arb_to_udp_data_val, 1'b1);
      check("bp_hold_data", arb_to_udp_data, beat_word(1'b1, id_m, 1));
      check("bp_setup_rdy", {arb_setup_meta_rdy, arb_setup_data_rdy}, 2'b00);
    end
    @(posedge clk); #1;
    to_udp_arb_data_rdy = 1'b1;
    wait_done(100, "bp");
    check("bp_order_len", order_q.size(), 2);
    if (order_q.size() == 2) check("bp_order", {order_q[0], order_q[1]}, 2'b10);
    if (beat_cyc_q.size() >= 2) check("bp_stall_len", beat_cyc_q[1] - beat_cyc_q[0], 6);

    // Reset in the middle of a 4-beat setup message, on beat 2.
    reset_dut();
    id_s = next_id[0];
    done = 2'b10;
    fork run_src(1'b0, 1, 4, 0); join_none
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (arb_to_udp_data_val && arb_to_udp_data == beat_word(1'b0, id_s, 0)) found = 1'b1;
    end
    check("rstmid_beat1_seen", found, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    to_udp_arb_data_rdy = 1'b0;
    @(negedge clk);
    check("rstmid_beat2", {arb_to_udp_data_val, arb_to_udp_data}, {1'b1, beat_word(1'b0, id_s, 1)});
    abort = 1'b1;
    @(negedge clk);
    check("rstmid_outputs", {arb_to_udp_meta_val, arb_to_udp_data_val, arb_setup_meta_rdy,
                             arb_setup_data_rdy, arb_manage_meta_rdy, arb_manage_data_rdy}, 6'b0);
    wait_done(20, "rstmid_drv");
    @(posedge clk); #1;
    rst = 1'b0;
    abort = 1'b0;
    to_udp_arb_data_rdy = 1'b1;
    clear_logs();
    done = 2'b00;
    fork
      run_src(1'b0, 1, 1, 0);
      run_src(1'b1, 1, 1, 0);
    join_none
    wait_done(100, "rstmid_after");
    check("rstmid_after_len", order_q.size(), 2);
    if (order_q.size() == 2) begin
      check("rstmid_prio_setup", {order_q[0], order_q[1]}, 2'b01);
      check("rstmid_arb_lat", meta_cyc_q[0] - req_cyc[0], 1);
    end

    // Random val/rdy stress, 1000 messages per source.
    reset_dut();
    base0 = n_meta[0];
    base1 = n_meta[1];
    done = 2'b00;
    stop_rdy = 1'b0;
    fork
      run_src(1'b0, 1000, 0, 25);
      run_src(1'b1, 1000, 0, 25);
      while (!stop_rdy) begin
        @(posedge clk); #1;
        to_udp_arb_meta_rdy = ($urandom_range(0, 99) < 70);
        to_udp_arb_data_rdy = ($urandom_range(0, 99) < 70);
      end
    join_none
    wait_done(60000, "stress");
    stop_rdy = 1'b1;
    @(posedge clk); #2;
    to_udp_arb_meta_rdy = 1'b1;
    to_udp_arb_data_rdy = 1'b1;
    repeat (4) @(posedge clk);
    check("stress_setup_msgs", n_meta[0] - base0, 1000);
    check("stress_manage_msgs", n_meta[1] - base1, 1000);
    check("stress_setup_meta_left", exp_meta_q0.size(), 0);
    check("stress_manage_meta_left", exp_meta_q1.size(), 0);
    check("stress_setup_beats_left", exp_q0.size(), 0);
    check("stress_manage_beats_left", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
